// File: rtl/sparse_matmul_pkg.sv
// rtl/sparse_matmul_pkg.sv - shared widths and FSM state for the N:M sparse tile multiplier
package sparse_matmul_pkg;

  typedef enum logic [1:0] {LOAD, COMPUTE, OUT} state_t;

  function automatic int idx_w(input int block_num);
    return (block_num > 1) ? $clog2(block_num) : 1;
  endfunction

  function automatic int block_size(input int m, input int block_num);
    return m / block_num;
  endfunction

  function automatic int keep_w(input int keep_max);
    return $clog2(keep_max + 1);
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int prod_w(input int a_width, input int b_width);
    return a_width + b_width;
  endfunction

  // One row's worth of products: KEEP_MAX*BLOCK_SIZE terms.
  function automatic int psum_w(input int a_width, input int b_width, input int keep_max, input int bsize);
    return prod_w(a_width, b_width) + $clog2(keep_max * bsize);
  endfunction

  // Full reduction including the IN_DEPTH tiles folded into the accumulator.
  function automatic int acc_w(input int a_width, input int b_width, input int keep_max, input int bsize,
                               input int depth);
    return prod_w(a_width, b_width) + $clog2(keep_max * bsize * depth);
  endfunction

endpackage

// File: rtl/nm_sparse_row_mac.sv
// rtl/nm_sparse_row_mac.sv - combinational MAC of one compressed A row against the dense B tile
module nm_sparse_row_mac
  import sparse_matmul_pkg::*;
#(
  parameter int M         = 4,
  parameter int K         = 2,
  parameter int BLOCK_NUM = 2,
  parameter int KEEP_MAX  = 1,
  parameter int A_WIDTH   = 8,
  parameter int B_WIDTH   = 8,
  localparam int BLOCK_SIZE = block_size(M, BLOCK_NUM),
  localparam int IDX_W      = idx_w(BLOCK_NUM),
  localparam int KEEP_W     = keep_w(KEEP_MAX),
  localparam int PROD_W     = prod_w(A_WIDTH, B_WIDTH),
  localparam int PSUM_W     = psum_w(A_WIDTH, B_WIDTH, KEEP_MAX, BLOCK_SIZE)
) (
  input  logic [KEEP_MAX*BLOCK_SIZE*A_WIDTH-1:0] a_row,
  input  logic [KEEP_MAX*IDX_W-1:0]              idx_row,
  input  logic [M*K*B_WIDTH-1:0]                 b_tile,
  input  logic [KEEP_W-1:0]                      keep,
  output logic [K*PSUM_W-1:0]                    psum,
  output logic                                   dup
);

  logic signed [PSUM_W-1:0]  sum_k [K];
  logic signed [PROD_W-1:0]  prod;
  logic signed [A_WIDTH-1:0] a_e;
  logic signed [B_WIDTH-1:0] b_e;
  int                        row;

  // Gather B rows addressed by each active slot's block index and sum the products per column.
  // Out-of-range indices (non-power-of-two BLOCK_NUM) contribute nothing.
  always_comb begin
    prod = '0;
    a_e  = '0;
    b_e  = '0;
    row  = 0;
    psum = '0;
    for (int k = 0; k < K; k++) sum_k[k] = '0;
    for (int k = 0; k < K; k++) begin
      for (int s = 0; s < KEEP_MAX; s++) begin
        for (int e = 0; e < BLOCK_SIZE; e++) begin
          if (s < int'(keep) && int'(idx_row[s*IDX_W +: IDX_W]) < BLOCK_NUM) begin
            row      = int'(idx_row[s*IDX_W +: IDX_W]) * BLOCK_SIZE + e;
            a_e      = a_row[(s*BLOCK_SIZE+e)*A_WIDTH +: A_WIDTH];
            b_e      = b_tile[(row*K+k)*B_WIDTH +: B_WIDTH];
            prod     = PROD_W'(a_e) * PROD_W'(b_e);
            sum_k[k] = sum_k[k] + PSUM_W'(prod);
          end
        end
      end
    end
    for (int k = 0; k < K; k++) psum[k*PSUM_W +: PSUM_W] = sum_k[k];
  end

  // Flag any two active slots of this row that point at the same block.
  always_comb begin
    dup = 1'b0;
    for (int s1 = 0; s1 < KEEP_MAX; s1++) begin
      for (int s2 = s1 + 1; s2 < KEEP_MAX; s2++) begin
        if (s2 < int'(keep) && idx_row[s1*IDX_W +: IDX_W] == idx_row[s2*IDX_W +: IDX_W]) dup = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nm_sparse_tile_matmul.sv
// rtl/nm_sparse_tile_matmul.sv - row-serial N:M sparse tile multiplier with depth accumulation and saturating cast
module nm_sparse_tile_matmul
  import sparse_matmul_pkg::*;
#(
  parameter int N              = 2,
  parameter int M              = 4,
  parameter int K              = 2,
  parameter int BLOCK_NUM      = 2,
  parameter int KEEP_MAX       = 1,
  parameter int IN_DEPTH       = 2,
  parameter int A_WIDTH        = 8,
  parameter int A_FRAC_WIDTH   = 1,
  parameter int B_WIDTH        = 8,
  parameter int B_FRAC_WIDTH   = 1,
  parameter int OUT_WIDTH      = 16,
  parameter int OUT_FRAC_WIDTH = 2,
  localparam int BLOCK_SIZE = block_size(M, BLOCK_NUM),
  localparam int IDX_W      = idx_w(BLOCK_NUM),
  localparam int KEEP_W     = keep_w(KEEP_MAX)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [N*KEEP_MAX*BLOCK_SIZE*A_WIDTH-1:0] a_data,
  input  logic [N*KEEP_MAX*IDX_W-1:0]             a_idx,
  input  logic                                    a_valid,
  output logic                                    a_ready,
  input  logic [M*K*B_WIDTH-1:0]                  b_data,
  input  logic                                    b_valid,
  output logic                                    b_ready,
  input  logic [KEEP_W-1:0]                       cfg_keep,
  output logic [N*K*OUT_WIDTH-1:0]                out_data,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic                                    err_dup_idx
);

  localparam int PSUM_W  = psum_w(A_WIDTH, B_WIDTH, KEEP_MAX, BLOCK_SIZE);
  localparam int ACC_W   = acc_w(A_WIDTH, B_WIDTH, KEEP_MAX, BLOCK_SIZE, IN_DEPTH);
  localparam int ROW_A_W = KEEP_MAX * BLOCK_SIZE * A_WIDTH;
  localparam int ROW_I_W = KEEP_MAX * IDX_W;
  localparam int ROW_W   = cnt_w(N);
  localparam int DEPTH_W = cnt_w(IN_DEPTH);
  localparam int SHIFT   = A_FRAC_WIDTH + B_FRAC_WIDTH - OUT_FRAC_WIDTH;
  localparam int EXT_W   = ((ACC_W > OUT_WIDTH) ? ACC_W : OUT_WIDTH) + 1;
  localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN = {{(EXT_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  state_t                   state, state_next;
  logic [N*ROW_A_W-1:0]     a_q;
  logic [N*ROW_I_W-1:0]     idx_q;
  logic [M*K*B_WIDTH-1:0]   b_q;
  logic [KEEP_W-1:0]        keep_q;
  logic [KEEP_W-1:0]        keep_clamped;
  logic [ROW_W-1:0]         row_cnt;
  logic [DEPTH_W-1:0]       depth_cnt;
  logic signed [ACC_W-1:0]  acc [N][K];
  logic [ROW_A_W-1:0]       a_row_sel;
  logic [ROW_I_W-1:0]       idx_row_sel;
  logic [K*PSUM_W-1:0]      psum;
  logic                     row_dup;
  logic                     accept, last_row, last_depth, out_fire;
  logic signed [EXT_W-1:0]  shifted;

  assign accept       = (state == LOAD) && a_valid && b_valid;
  assign last_row     = (int'(row_cnt) == N - 1);
  assign last_depth   = (int'(depth_cnt) == IN_DEPTH - 1);
  assign out_fire     = (state == OUT) && out_ready;
  assign keep_clamped = (int'(cfg_keep) > KEEP_MAX) ? KEEP_W'(KEEP_MAX) : cfg_keep;
  assign a_row_sel    = a_q[int'(row_cnt)*ROW_A_W +: ROW_A_W];
  assign idx_row_sel  = idx_q[int'(row_cnt)*ROW_I_W +: ROW_I_W];

  nm_sparse_row_mac #(
    .M         (M),
    .K         (K),
    .BLOCK_NUM (BLOCK_NUM),
    .KEEP_MAX  (KEEP_MAX),
    .A_WIDTH   (A_WIDTH),
    .B_WIDTH   (B_WIDTH)
  ) u_row_mac (
    .a_row   (a_row_sel),
    .idx_row (idx_row_sel),
    .b_tile  (b_q),
    .keep    (keep_q),
    .psum    (psum),
    .dup     (row_dup)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_next;
  end

  // Next-state and handshake outputs; loads never overlap the output phase.
  always_comb begin
    state_next = state;
    a_ready    = 1'b0;
    b_ready    = 1'b0;
    out_valid  = 1'b0;
    case (state)
      LOAD: begin
        a_ready = 1'b1;
        b_ready = 1'b1;
        if (accept) state_next = COMPUTE;
      end
      COMPUTE: begin
        if (last_row) state_next = last_depth ? OUT : LOAD;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = LOAD;
      end
      default: state_next = LOAD;
    endcase
  end

  // Tile capture, row/depth counters; keep is frozen for the whole accumulation group.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      idx_q     <= '0;
      b_q       <= '0;
      keep_q    <= '0;
      row_cnt   <= '0;
      depth_cnt <= '0;
    end else begin
      if (accept) begin
        a_q     <= a_data;
        idx_q   <= a_idx;
        b_q     <= b_data;
        row_cnt <= '0;
        if (depth_cnt == '0) keep_q <= keep_clamped;
      end
      if (state == COMPUTE) begin
        if (last_row) begin
          row_cnt   <= '0;
          depth_cnt <= last_depth ? '0 : depth_cnt + 1'b1;
        end else begin
          row_cnt <= row_cnt + 1'b1;
        end
      end
    end
  end

  // Accumulate the current row's partial sums; cleared when the C tile is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < N; r++)
        for (int k = 0; k < K; k++) acc[r][k] <= '0;
    end else if (out_fire) begin
      for (int r = 0; r < N; r++)
        for (int k = 0; k < K; k++) acc[r][k] <= '0;
    end else if (state == COMPUTE) begin
      for (int r = 0; r < N; r++)
        for (int k = 0; k < K; k++)
          if (int'(row_cnt) == r)
            acc[r][k] <= acc[r][k] + ACC_W'($signed(psum[k*PSUM_W +: PSUM_W]));
    end
  end

  // Sticky duplicate-index flag, raised while the offending row is computed.
  always_ff @(posedge clk) begin
    if (rst)                          err_dup_idx <= 1'b0;
    else if (state == COMPUTE && row_dup) err_dup_idx <= 1'b1;
  end

  // Floor by arithmetic shift, then clamp into the signed output range.
  always_comb begin
    shifted  = '0;
    out_data = '0;
    for (int r = 0; r < N; r++) begin
      for (int k = 0; k < K; k++) begin
        shifted = EXT_W'(acc[r][k]) >>> SHIFT;
        if (shifted > SAT_MAX)      out_data[(r*K+k)*OUT_WIDTH +: OUT_WIDTH] = SAT_MAX[OUT_WIDTH-1:0];
        else if (shifted < SAT_MIN) out_data[(r*K+k)*OUT_WIDTH +: OUT_WIDTH] = SAT_MIN[OUT_WIDTH-1:0];
        else                        out_data[(r*K+k)*OUT_WIDTH +: OUT_WIDTH] = shifted[OUT_WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_nm_sparse_tile_matmul.sv
// tb/tb_nm_sparse_tile_matmul.sv - directed self-checking bench for the sparse tile multiplier
module tb_nm_sparse_tile_matmul;

  localparam int N = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] a_data;
  logic [3:0]  a_idx;
  logic        a_valid;
  logic        a_ready;
  logic [63:0] b_data;
  logic        b_valid;
  logic        b_ready;
  logic [1:0]  cfg_keep;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        err_dup_idx;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  // free-running edge counter used for latency measurement
  always @(posedge clk) cyc <= cyc + 1;

  nm_sparse_tile_matmul #(
    .N(2), .M(4), .K(2), .BLOCK_NUM(2), .KEEP_MAX(2), .IN_DEPTH(2),
    .A_WIDTH(8), .A_FRAC_WIDTH(1), .B_WIDTH(8), .B_FRAC_WIDTH(1),
    .OUT_WIDTH(16), .OUT_FRAC_WIDTH(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .a_data      (a_data),
    .a_idx       (a_idx),
    .a_valid     (a_valid),
    .a_ready     (a_ready),
    .b_data      (b_data),
    .b_valid     (b_valid),
    .b_ready     (b_ready),
    .cfg_keep    (cfg_keep),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .err_dup_idx (err_dup_idx)
  );

  // A: element r*4+s*2+e ; B: element m*2+k ; both 8-bit, element 0 in the LSBs
  function automatic logic [63:0] pack8(input int v0, input int v1, input int v2, input int v3,
                                        input int v4, input int v5, input int v6, input int v7);
    return {v7[7:0], v6[7:0], v5[7:0], v4[7:0], v3[7:0], v2[7:0], v1[7:0], v0[7:0]};
  endfunction

  function automatic logic [63:0] pack_out(input int c00, input int c01, input int c10, input int c11);
    return {c11[15:0], c10[15:0], c01[15:0], c00[15:0]};
  endfunction

  logic [63:0] a_dense, a_zero, b_id2, b_alt, a_dep, b_dep;

  task automatic put_tile(input logic [63:0] a, input logic [3:0] idx, input logic [63:0] b,
                          input logic [1:0] keep, output int t_acc);
    int n;
    n = 0;
    @(negedge clk);
    while (!a_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!a_ready) begin
      total++;
      bad++;
      $display("FAIL put_tile_timeout a_ready=%b required=1", a_ready);
    end
    a_data = a; a_idx = idx; b_data = b; cfg_keep = keep;
    a_valid = 1'b1; b_valid = 1'b1;
    @(posedge clk); #1;
    t_acc = cyc;
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic get_out(output logic [63:0] d, output int t_out);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) begin
      total++;
      bad++;
      $display("FAIL get_out_timeout out_valid=%b required=1", out_valid);
    end
    t_out = cyc;
    d = out_data;
  endtask

  task automatic take_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_group(input logic [63:0] a1, input logic [3:0] i1, input logic [63:0] b1, input logic [1:0] k1,
                           input logic [63:0] a2, input logic [3:0] i2, input logic [63:0] b2, input logic [1:0] k2,
                           output logic [63:0] d, output int lat);
    int t0, t1, t2;
    put_tile(a1, i1, b1, k1, t0);
    put_tile(a2, i2, b2, k2, t1);
    get_out(d, t2);
    lat = t2 - t1;
    take_out();
  endtask

  task automatic test_reset();
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;
    a_data = '0; a_idx = '0; b_data = '0; cfg_keep = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    total++; if (a_ready !== 1'b1)     begin bad++; $display("FAIL reset_a_ready got=%b exp=1", a_ready); end
    total++; if (b_ready !== 1'b1)     begin bad++; $display("FAIL reset_b_ready got=%b exp=1", b_ready); end
    total++; if (out_valid !== 1'b0)   begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (err_dup_idx !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err_dup_idx); end
  endtask

  // two active slots per row, second tile all-zero so only the first contributes
  task automatic test_dense();
    logic [63:0] d, exp;
    int lat;
    run_group(a_dense, 4'b1010, b_id2, 2'd2, a_zero, 4'b1010, b_id2, 2'd2, d, lat);
    exp = pack_out(2, 4, 10, 12);
    total++; if (d !== exp) begin bad++; $display("FAIL dense_data got=%h exp=%h", d, exp); end
    // out_valid first seen N edges after the accept edge, i.e. cycle T+N+1
    total++; if (lat !== N) begin bad++; $display("FAIL dense_latency got=%0d exp=%0d", lat, N); end
  endtask

  // 2:4 sparsity; cfg_keep changed to 2 on the second tile must be ignored
  task automatic test_sparse_24();
    logic [63:0] a, b, d, exp;
    int lat;
    a = pack8(5, 6, 9, 9, 1, 1, 9, 9);
    b = pack8(50, -3, 7, 9, 1, 0, 0, 1);
    run_group(a, 4'b1001, b, 2'd1, a, 4'b1001, b, 2'd2, d, lat);
    exp = pack_out(10, 12, 114, 12);
    total++; if (d !== exp) begin bad++; $display("FAIL sparse24_data got=%h exp=%h", d, exp); end
  endtask

  task automatic test_depth_backpressure();
    logic [63:0] d, exp, held;
    int t0, t1, t2, early, unstable;
    early = 0;
    unstable = 0;
    put_tile(a_dep, 4'b0100, b_dep, 2'd1, t0);
    repeat (4) begin
      @(posedge clk); #1;
      if (out_valid) early++;
    end
    total++; if (early !== 0) begin bad++; $display("FAIL depth_early_out got=%0d exp=0", early); end
    put_tile(a_dep, 4'b0100, b_dep, 2'd1, t1);
    get_out(d, t2);
    exp = pack_out(14, 10, 12, -4);
    total++; if (d !== exp) begin bad++; $display("FAIL depth_data got=%h exp=%h", d, exp); end
    total++; if (t2 - t1 !== N) begin bad++; $display("FAIL depth_latency got=%0d exp=%0d", t2 - t1, N); end
    held = out_data;
    repeat (5) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || a_ready !== 1'b0 || b_ready !== 1'b0 || out_data !== held) unstable++;
    end
    total++; if (unstable !== 0) begin bad++; $display("FAIL backpressure_hold got=%0d exp=0", unstable); end
    take_out();
    total++; if (a_ready !== 1'b1)   begin bad++; $display("FAIL release_a_ready got=%b exp=1", a_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL release_out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_saturation();
    logic [63:0] a, b, d, exp;
    int lat;
    a = pack8(127, 127, 127, 127, 127, 127, 127, 127);
    b = a;
    run_group(a, 4'b1010, b, 2'd2, a, 4'b1010, b, 2'd2, d, lat);
    exp = pack_out(32767, 32767, 32767, 32767);
    total++; if (d !== exp) begin bad++; $display("FAIL sat_pos got=%h exp=%h", d, exp); end
    a = pack8(-128, -128, -128, -128, -128, -128, -128, -128);
    run_group(a, 4'b1010, b, 2'd2, a, 4'b1010, b, 2'd2, d, lat);
    exp = pack_out(-32768, -32768, -32768, -32768);
    total++; if (d !== exp) begin bad++; $display("FAIL sat_neg got=%h exp=%h", d, exp); end
  endtask

  task automatic test_keep_edges();
    logic [63:0] d, exp;
    int lat;
    run_group(a_dense, 4'b1010, b_alt, 2'd0, a_dense, 4'b1010, b_alt, 2'd0, d, lat);
    total++; if (d !== 64'd0) begin bad++; $display("FAIL keep_zero got=%h exp=0", d); end
    // keep=3 clamps to KEEP_MAX=2 so both slots count
    run_group(a_dense, 4'b1010, b_alt, 2'd3, a_zero, 4'b1010, b_alt, 2'd3, d, lat);
    exp = pack_out(4, 6, 12, 14);
    total++; if (d !== exp) begin bad++; $display("FAIL keep_clamp got=%h exp=%h", d, exp); end
  endtask

  task automatic test_dup();
    logic [63:0] d, exp;
    int lat;
    total++; if (err_dup_idx !== 1'b0) begin bad++; $display("FAIL dup_pre_err got=%b exp=0", err_dup_idx); end
    run_group(a_dense, 4'b0000, b_id2, 2'd2, a_zero, 4'b0000, b_id2, 2'd2, d, lat);
    exp = pack_out(8, 12, 24, 28);
    total++; if (d !== exp) begin bad++; $display("FAIL dup_data got=%h exp=%h", d, exp); end
    total++; if (err_dup_idx !== 1'b1) begin bad++; $display("FAIL dup_err got=%b exp=1", err_dup_idx); end
    run_group(a_dense, 4'b1010, b_id2, 2'd2, a_zero, 4'b1010, b_id2, 2'd2, d, lat);
    total++; if (err_dup_idx !== 1'b1) begin bad++; $display("FAIL dup_sticky got=%b exp=1", err_dup_idx); end
  endtask

  // reset during the second tile of a group, then a fresh group must be unpolluted
  task automatic test_reset_mid();
    logic [63:0] d, exp;
    int t, lat;
    put_tile(a_dep, 4'b0100, b_dep, 2'd1, t);
    put_tile(a_dep, 4'b0100, b_dep, 2'd1, t);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (out_valid !== 1'b0)   begin bad++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
    total++; if (err_dup_idx !== 1'b0) begin bad++; $display("FAIL midrst_err got=%b exp=0", err_dup_idx); end
    total++; if (a_ready !== 1'b1)     begin bad++; $display("FAIL midrst_a_ready got=%b exp=1", a_ready); end
    run_group(a_dep, 4'b0100, b_dep, 2'd1, a_dep, 4'b0100, b_dep, 2'd1, d, lat);
    exp = pack_out(14, 10, 12, -4);
    total++; if (d !== exp) begin bad++; $display("FAIL midrst_fresh got=%h exp=%h", d, exp); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    a_dense = pack8(1, 2, 3, 4, 5, 6, 7, 8);
    a_zero  = 64'd0;
    b_id2   = pack8(2, 0, 0, 2, 0, 0, 0, 0);
    b_alt   = pack8(1, 0, 0, 1, 1, 0, 0, 1);
    a_dep   = pack8(1, 3, 0, 0, 2, 0, 0, 0);
    b_dep   = pack8(1, 2, 2, 1, 3, -1, 0, 0);
    test_reset();
    test_dense();
    test_sparse_24();
    test_depth_backpressure();
    test_saturation();
    test_keep_edges();
    test_dup();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nm_sparse_tile_matmul.md
Name: nm_sparse_tile_matmul

Overview:
Row-serial structured N:M sparse tile multiplier with runtime-selectable sparsity. Matrix A arrives compressed: per row, up to KEEP_MAX non-zero blocks of BLOCK_SIZE elements, each with a block index. Matrix B arrives as a dense tile. The block gathers the matching B rows, accumulates over IN_DEPTH reduction tiles, then emits a floor-rounded, saturated C tile. It sits between the weight/activation tile buffers and the output stream, as the next-generation compute core for sparse matmul.

Parameters:
N, 2, rows of A tile / C tile
M, 4, reduction dim of the tile (A cols = B rows)
K, 2, cols of B tile / C tile
BLOCK_NUM, 2, blocks per A row; BLOCK_SIZE = M/BLOCK_NUM (localparam)
KEEP_MAX, 1, max non-zero blocks per row (1..BLOCK_NUM)
IN_DEPTH, 2, reduction tiles accumulated per output tile
A_WIDTH, 8, A element width; A_FRAC_WIDTH, 1
B_WIDTH, 8, B element width; B_FRAC_WIDTH, 1
OUT_WIDTH, 16, output width; OUT_FRAC_WIDTH, 2 (must be <= A_FRAC_WIDTH+B_FRAC_WIDTH)

Ports:
clk  in  1  clock
rst  in  1  reset
a_data  in  [A_WIDTH] x N*KEEP_MAX*BLOCK_SIZE  compressed A, row-major, slot-major within a row
a_idx  in  [IDX_W] x N*KEEP_MAX  block index per slot; IDX_W = max(1,$clog2(BLOCK_NUM))
a_valid / a_ready  in / out  1  A handshake
b_data  in  [B_WIDTH] x M*K  dense B tile, row-major
b_valid / b_ready  in / out  1  B handshake
cfg_keep  in  $clog2(KEEP_MAX+1)  active slots per row
out_data  out  [OUT_WIDTH] x N*K  C tile, row-major
out_valid / out_ready  out / in  1  C handshake
err_dup_idx  out  1  sticky flag: duplicate index among active slots of a row

Behaviour:
- One clock, clk; reset rst is synchronous and active-high. Reset: state=LOAD, accumulators=0, depth_cnt=0, row_cnt=0, out_valid=0, err_dup_idx=0, a_ready=b_ready=1.
- FSM LOAD: a_ready=b_ready=1.
  - Tile accepted only in a cycle with a_valid&&b_valid; both are captured together, with no partial acceptance.
  - On accept: capture A, idx, B; if depth_cnt==0, latch cfg_keep into keep_q; go to COMPUTE with row_cnt=0.
- FSM COMPUTE: a_ready=b_ready=0; one A row per cycle.
  - acc[r][k] += sum over s<keep_q, e<BLOCK_SIZE of a[r][s][e]*b[idx[r][s]*BLOCK_SIZE+e][k], signed.
  - After row N-1: if depth_cnt==IN_DEPTH-1, go to OUT and clear depth_cnt; else depth_cnt++ and go to LOAD.
- FSM OUT: out_valid=1, out_data stable until out_ready.
  - On handshake: clear acc; go to LOAD in the next cycle. No load overlaps OUT.
- Latency: last tile accepted at cycle T -> out_valid at T+N+1. Throughput: one tile per N+1 cycles.
- Widths: PROD_W = A_WIDTH+B_WIDTH; ACC_W = PROD_W + $clog2(KEEP_MAX*BLOCK_SIZE*IN_DEPTH); no internal overflow.
- Output cast: arithmetic right shift by A_FRAC_WIDTH+B_FRAC_WIDTH-OUT_FRAC_WIDTH (floor), then saturate to signed OUT_WIDTH range.
- cfg_keep==0: all products zero, so the output is 0. cfg_keep>KEEP_MAX is clamped to KEEP_MAX. Changes to cfg_keep mid-group are ignored.
- Index >= BLOCK_NUM (non-power-of-two BLOCK_NUM): that slot contributes 0.
- Duplicate active index in a row: both slots contribute (summed); err_dup_idx sets and stays set until rst.
- rst asserted mid-COMPUTE or mid-OUT: partial sums are discarded and all state returns to reset values next cycle.

Decomposition:
- Package sparse_matmul_pkg: IDX_W, BLOCK_SIZE, PROD_W and ACC_W width functions, and the FSM state enum {LOAD, COMPUTE, OUT}.
- Sub-module nm_sparse_row_mac: purely combinational; one compressed A row plus B tile plus keep_q -> K partial sums of width PROD_W+$clog2(KEEP_MAX*BLOCK_SIZE), plus a dup flag.
- The top level holds the FSM, the tile registers, the accumulators and the cast.

Test Plan:
- Dense: KEEP_MAX=BLOCK_NUM=2, cfg_keep=2, A rows [1,2,3,4] (raw, frac 1), B = identity*2 (raw), IN_DEPTH=1 -> out raw equals A*2*2>>0 scaled, i.e. row0 = [2,4] for K=2 cols 0,1; matches numpy reference.
- 2:4 sparsity: cfg_keep=1; row0 idx=1 with data [5,6]; B rows 2,3 = [[1,0],[0,1]] -> out row0 = [10,12] raw (frac 2). Result is independent of B rows 0,1.
- Depth accumulation: IN_DEPTH=2, two identical tiles giving 7 each -> single out_valid with 14; no output after tile 1; out_valid at T+N+1.
- Backpressure: hold out_ready=0 for 5 cycles -> out_data stable, a_ready=0 throughout. Release -> handshake, then a_ready=1 next cycle.
- Saturation/edge: A=B=all 0x7F with cfg_keep=KEEP_MAX -> out=0x7FFF. cfg_keep=0 -> out=0.
- Error/reset: duplicate idx {0,0} with cfg_keep=2 -> err_dup_idx=1 and both slots summed. Assert rst during COMPUTE -> out_valid=0 and err=0; a fresh tile produces the correct result unpolluted by prior sums.
